// File: rtl/systolic_result_writer.sv
// Drains result vectors from the 4x4 systolic array and writes them one word per
// cycle into the result RAM through an en/we/addr/di write port.
module systolic_result_writer #(
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 4,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_VECTORS = 4,
    parameter int BASE_ADDR   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   res_data,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_di,
    output logic                          busy,
    output logic                          done
);

    localparam int VW    = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W = LANES * DATA_WIDTH;
    localparam logic [VW-1:0] LAST_VEC  = VW'(NUM_VECTORS - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [VW-1:0]           vec_cnt_q, vec_cnt_d;
    logic [LW-1:0]           lane_cnt_q, lane_cnt_d;
    logic [VEC_W-1:0]        vec_q, vec_d;
    logic [VEC_W-1:0]        src_vec;
    logic                    res_ready_q, res_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_di_q, ram_di_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_cnt_q   <= '0;
            lane_cnt_q  <= '0;
            res_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_di_q    <= '0;
        end else begin
            state_q     <= state_d;
            vec_cnt_q   <= vec_cnt_d;
            lane_cnt_q  <= lane_cnt_d;
            res_ready_q <= res_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_q        <= wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_di_q    <= ram_di_d;
        end
    end

    // The latched vector is pure data; it is only meaningful after a handshake.
    always_ff @(posedge clk) begin
        vec_q <= vec_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCEPT;
            ACCEPT:  if (res_valid) state_d = WRITE;
            WRITE: begin
                if (lane_cnt_q == LAST_LANE) begin
                    state_d = (vec_cnt_q == LAST_VEC) ? DONE : ACCEPT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_cnt_d  = vec_cnt_q;
        lane_cnt_d = lane_cnt_q;
        vec_d      = vec_q;
        src_vec    = vec_q;
        case (state_q)
            IDLE: begin
                if (start) vec_cnt_d = '0;
            end
            ACCEPT: begin
                if (res_valid) begin
                    vec_d      = res_data;
                    src_vec    = res_data;
                    lane_cnt_d = '0;
                end
            end
            WRITE: begin
                if (lane_cnt_q == LAST_LANE) begin
                    if (vec_cnt_q != LAST_VEC) vec_cnt_d = vec_cnt_q + 1'b1;
                end else begin
                    lane_cnt_d = lane_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        res_ready_d = (state_d == ACCEPT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        wr_d        = (state_d == WRITE);
        ram_addr_d  = ram_addr_q;
        ram_di_d    = ram_di_q;
        if (wr_d) begin
            ram_addr_d = ADDR_WIDTH'(32'(BASE_ADDR) + 32'(vec_cnt_d) * 32'(LANES)
                                     + 32'(lane_cnt_d));
            ram_di_d   = src_vec[32'(lane_cnt_d) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign res_ready = res_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_en    = wr_q;
    assign ram_we    = wr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_di    = ram_di_q;

endmodule

// File: tb/tb_systolic_result_writer.sv
// Directed bench for systolic_result_writer: table of result vectors with expected
// RAM writes, plus hand-written sequences for stall, abort, wrap and chaining.
module tb_systolic_result_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, res_valid, res_ready;
    logic [63:0] res_data;
    logic        ram_en, ram_we, busy, done;
    logic [3:0]  ram_addr;
    logic [15:0] ram_di;

    logic        b_rst, b_start, b_res_valid, b_res_ready;
    logic [63:0] b_res_data;
    logic        b_ram_en, b_ram_we, b_busy, b_done;
    logic [3:0]  b_ram_addr;
    logic [15:0] b_ram_di;

    systolic_result_writer dut (
        .clk(clk), .rst(rst), .start(start), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .ram_en(ram_en),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .busy(busy), .done(done)
    );

    systolic_result_writer #(.BASE_ADDR(12), .NUM_VECTORS(2)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .res_valid(b_res_valid),
        .res_ready(b_res_ready), .res_data(b_res_data), .ram_en(b_ram_en),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_di(b_ram_di),
        .busy(b_busy), .done(b_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // RAM model and event counters for the main instance
    logic [15:0] mem [16];
    int  wr_count = 0;
    int  done_cnt = 0;
    int  cyc      = 0;
    bit  clr_mem  = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'hDEAD;
        end else if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_di;
            wr_count      <= wr_count + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    logic [3:0]  b_addr_log [$];
    logic [15:0] b_data_log [$];
    always @(posedge clk) begin
        if (b_ram_en && b_ram_we) begin
            b_addr_log.push_back(b_ram_addr);
            b_data_log.push_back(b_ram_di);
        end
    end

    typedef struct {
        logic [63:0]      vec;
        logic [3:0]       a0;
        logic [3:0][15:0] exp;
        int               stall;
        bit               poke;
    } rec_t;

    rec_t tbl [10];

    task automatic send_rec(input rec_t r);
        int n;
        n = 0;
        while (res_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_handshake", res_ready, 1);
        if (r.stall > 0) begin
            res_valid = 1'b0;
            for (int i = 0; i < r.stall; i++) begin
                @(negedge clk);
                chk("stall_ready", res_ready, 1);
                chk("stall_no_write", ram_en, 0);
            end
        end
        res_data  = r.vec;
        res_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("wr_en", ram_en, 1);
            chk("wr_we", ram_we, 1);
            chk("wr_addr", ram_addr, r.a0 + 4'(k));
            chk("wr_data", ram_di, r.exp[k]);
            chk("wr_ready_low", res_ready, 0);
            res_data = ~r.vec;
            start    = r.poke && (k == 1);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Runs a full drain from IDLE; optionally holds start through DONE into IDLE.
    task automatic drain(input int first, input bit next_start);
        int t0, stalls;
        stalls = 0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        chk("busy_after_start", busy, 1);
        for (int i = first; i < first + 4; i++) begin
            stalls += tbl[i].stall;
            send_rec(tbl[i]);
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_no_write", ram_en, 0);
        chk("done_latency", 64'(cyc - t0), 64'(20 + stalls));
        start = next_start;
        @(negedge clk);
        res_valid = 1'b0;
        chk("idle_done_low", done, 0);
        chk("idle_busy_low", busy, 0);
        chk("idle_ready_low", res_ready, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, res_ready, 0);
        chk({tag, "_en"}, ram_en, 0);
        chk({tag, "_we"}, ram_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_di"}, ram_di, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  b_ea [8];
        logic [15:0] b_ed [8];
        logic [63:0] b_vec [2];
        int n, wc;

        tbl[0] = '{64'h0004_0003_0002_0001, 4'd0,  {16'd4,  16'd3,  16'd2,  16'd1},  0, 1'b0};
        tbl[1] = '{64'h0008_0007_0006_0005, 4'd4,  {16'd8,  16'd7,  16'd6,  16'd5},  0, 1'b0};
        tbl[2] = '{64'h000C_000B_000A_0009, 4'd8,  {16'd12, 16'd11, 16'd10, 16'd9},  0, 1'b1};
        tbl[3] = '{64'h0010_000F_000E_000D, 4'd12, {16'd16, 16'd15, 16'd14, 16'd13}, 0, 1'b0};
        tbl[4] = '{64'h0104_0103_0102_0101, 4'd0,  {16'h104, 16'h103, 16'h102, 16'h101}, 0, 1'b0};
        tbl[5] = '{64'h0108_0107_0106_0105, 4'd4,  {16'h108, 16'h107, 16'h106, 16'h105}, 3, 1'b0};
        tbl[6] = '{64'h010C_010B_010A_0109, 4'd8,  {16'h10C, 16'h10B, 16'h10A, 16'h109}, 0, 1'b0};
        tbl[7] = '{64'h0110_010F_010E_010D, 4'd12, {16'h110, 16'h10F, 16'h10E, 16'h10D}, 0, 1'b1};
        tbl[8] = '{64'h0204_0203_0202_0201, 4'd0,  {16'h204, 16'h203, 16'h202, 16'h201}, 0, 1'b0};
        tbl[9] = '{64'h0208_0207_0206_0205, 4'd4,  {16'h208, 16'h207, 16'h206, 16'h205}, 0, 1'b0};

        b_ea  = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3};
        b_ed  = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55, 16'h66, 16'h77, 16'h88};
        b_vec = '{64'h0044_0033_0022_0011, 64'h0088_0077_0066_0055};

        rst = 1'b1; start = 1'b0; res_valid = 1'b0; res_data = '0;
        b_rst = 1'b1; b_start = 1'b0; b_res_valid = 1'b0; b_res_data = '0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0; b_rst = 1'b0;

        // res_valid while IDLE must be ignored
        res_valid = 1'b1;
        res_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_valid_ready", res_ready, 0);
            chk("idle_valid_busy", busy, 0);
            chk("idle_valid_en", ram_en, 0);
        end
        chk("idle_valid_writes", wr_count, 0);
        res_valid = 1'b0;

        // Basic drain (start poked mid-write), then a chained drain with a stall
        drain(0, 1'b1);
        chk("drain1_done_count", done_cnt, 1);
        for (int i = 0; i < 16; i++) chk("drain1_mem", mem[i], 64'(i + 1));
        drain(4, 1'b0);
        chk("drain2_done_count", done_cnt, 2);
        for (int i = 0; i < 16; i++) chk("drain2_mem", mem[i], 64'(16'h101 + i));

        // Abort on the second write of vector 1
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_rec(tbl[8]);
        n = 0;
        while (res_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_ready", res_ready, 1);
        res_data  = tbl[9].vec;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        chk("abort_wr0_addr", ram_addr, 4);
        chk("abort_wr0_data", ram_di, 16'h205);
        @(negedge clk);
        chk("abort_wr1_en", ram_en, 1);
        chk("abort_wr1_addr", ram_addr, 5);
        rst = 1'b1;
        @(negedge clk);
        chk_zero_outputs("abort");
        rst = 1'b0;
        wc  = wr_count;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle_en", ram_en, 0);
        end
        chk("abort_no_more_writes", wr_count, wc);
        chk("abort_mem0", mem[0], 16'h201);
        chk("abort_mem3", mem[3], 16'h204);
        chk("abort_mem4", mem[4], 16'h205);
        chk("abort_mem6", mem[6], 16'hDEAD);
        chk("abort_mem7", mem[7], 16'hDEAD);
        chk("abort_mem8", mem[8], 16'hDEAD);

        drain(0, 1'b0);
        for (int i = 0; i < 16; i++) chk("recover_mem", mem[i], 64'(i + 1));

        // Wrapping addresses on the BASE_ADDR=12, NUM_VECTORS=2 instance
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int v = 0; v < 2; v++) begin
            n = 0;
            while (b_res_ready !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("b_ready", b_res_ready, 1);
            b_res_data  = b_vec[v];
            b_res_valid = 1'b1;
            @(negedge clk);
            b_res_valid = 1'b0;
        end
        n = 0;
        while (b_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b_done", b_done, 1);
        chk("b_write_count", b_addr_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("b_addr", (i < b_addr_log.size()) ? 64'(b_addr_log[i]) : 64'hx, b_ea[i]);
            chk("b_data", (i < b_data_log.size()) ? 64'(b_data_log[i]) : 64'hx, b_ed[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
